// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the register-file sequencer and its register-file model.
// Contents: opcode values, instruction field bit positions, FSM state encoding,
// and opcode classification helpers (legality and writeback class).
package regfile_sequencer_pkg;

    localparam logic [4:0] OP_LW  = 5'd0;
    localparam logic [4:0] OP_SW  = 5'd1;
    localparam logic [4:0] OP_MOV = 5'd2;
    localparam logic [4:0] OP_ADD = 5'd3;
    localparam logic [4:0] OP_SUB = 5'd4;
    localparam logic [4:0] OP_MUL = 5'd5;
    localparam logic [4:0] OP_DIV = 5'd6;
    localparam logic [4:0] OP_AND = 5'd7;
    localparam logic [4:0] OP_OR  = 5'd8;
    localparam logic [4:0] OP_SHL = 5'd9;
    localparam logic [4:0] OP_SHR = 5'd10;
    localparam logic [4:0] OP_CMP = 5'd11;
    localparam logic [4:0] OP_NOT = 5'd12;

    // Instruction field positions
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 27;
    localparam int DEST_MSB = 26;
    localparam int DEST_LSB = 22;
    localparam int SRC1_MSB = 21;
    localparam int SRC1_LSB = 17;
    localparam int SRC2_MSB = 4;
    localparam int SRC2_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4
    } seq_state_e;

    // Opcodes above NOT are undefined
    function automatic logic is_legal(input logic [4:0] op);
        return (op <= OP_NOT);
    endfunction

    // Legal opcodes that produce a register-file write
    function automatic logic is_writeback(input logic [4:0] op);
        logic wb;
        case (op)
            OP_SW, OP_CMP: wb = 1'b0;
            default:       wb = is_legal(op);
        endcase
        return wb;
    endfunction

endpackage

// File: rtl/regfile_sequencer_timeout_counter.sv
// seq_timeout_counter: counts cycles spent waiting for a result.
// Ports: clk, reset (async active-high), clear (synchronous return to 0),
// enable (advance by one), terminal (count has reached LIMIT-1; saturates there).
module seq_timeout_counter #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int W = $clog2(LIMIT);

    logic [W-1:0] count_r;

    assign terminal = (count_r == W'(LIMIT - 1));

    // Wait-cycle count, held at the terminal value until cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (clear) begin
            count_r <= {W{1'b0}};
        end else if (enable && !terminal) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: issues one instruction at a time to the register file and
// execute stage: operand read, execute handshake, result wait, writeback.
// Ports: clk/reset; instr_in/instr_valid/instr_ready from fetch; rf_* register-file
// read/write interface; exec_* operands to the execute stage; result_valid/result_data
// back from execute; busy, timeout and illegal_op status; retired_count.
// All outputs are registered and derived from the next state.
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_in,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [31:0]      rf_instr,
    output logic [4:0]       rf_addr1,
    output logic [4:0]       rf_addr2,
    output logic             rf_enable_read,
    output logic             rf_enable_write,
    output logic [31:0]      rf_data,
    input  logic [31:0]      rf_data_out1,
    input  logic [31:0]      rf_data_out2,
    output logic             exec_valid,
    input  logic             exec_ready,
    output logic [4:0]       exec_op,
    output logic [31:0]      exec_a,
    output logic [31:0]      exec_b,
    input  logic             result_valid,
    input  logic [31:0]      result_data,
    output logic             busy,
    output logic             timeout,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_count
);

    seq_state_e state_r, state_next_s;

    logic [31:0]      instr_r, instr_next_s, result_r, result_next_s;
    logic [31:0]      exec_a_r, exec_b_r;
    logic [CNT_W-1:0] retired_count_r;
    logic [4:0]       in_op_s, cur_op_s;
    logic             retire_s, timeout_next_s, illegal_next_s;
    logic             wait_clear_s, wait_en_s, wait_terminal_s;

    logic             instr_ready_r, busy_r, rf_enable_read_r, rf_enable_write_r;
    logic             exec_valid_r, timeout_r, illegal_op_r;
    logic [4:0]       rf_addr1_r, rf_addr2_r, exec_op_r;
    logic [31:0]      rf_instr_r, rf_data_r;
    logic             instr_ready_next_s, busy_next_s, rf_enable_read_next_s;
    logic             rf_enable_write_next_s, exec_valid_next_s;
    logic [4:0]       rf_addr1_next_s, rf_addr2_next_s, exec_op_next_s;
    logic [31:0]      rf_instr_next_s, rf_data_next_s;

    assign in_op_s  = instr_in[OPC_MSB:OPC_LSB];
    assign cur_op_s = instr_r[OPC_MSB:OPC_LSB];

    assign wait_clear_s = (state_r != ST_WAIT);
    assign wait_en_s    = (state_r == ST_WAIT);

    seq_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (wait_clear_s),
        .enable   (wait_en_s),
        .terminal (wait_terminal_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid && is_legal(in_op_s)) begin
                    // MOV needs no operands: the register file does the copy itself
                    state_next_s = (in_op_s == OP_MOV) ? ST_WRITE : ST_READ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: state_next_s = ST_EXEC;
            ST_EXEC: begin
                if (exec_ready && result_valid) begin
                    state_next_s = is_writeback(cur_op_s) ? ST_WRITE : ST_IDLE;
                end else if (exec_ready) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_WAIT: begin
                // A result arriving on the terminal cycle still wins over the abort
                if (result_valid) begin
                    state_next_s = is_writeback(cur_op_s) ? ST_WRITE : ST_IDLE;
                end else if (wait_terminal_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_WRITE: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Datapath next values: instruction/result capture, retire, status pulses
    always_comb begin
        instr_next_s   = instr_r;
        result_next_s  = result_r;
        retire_s       = 1'b0;
        timeout_next_s = 1'b0;
        illegal_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_next_s   = instr_in;
                    result_next_s  = 32'd0;
                    illegal_next_s = !is_legal(in_op_s);
                end else begin
                    instr_next_s   = instr_r;
                end
            end
            ST_EXEC: begin
                if (exec_ready && result_valid) begin
                    result_next_s = result_data;
                    retire_s      = !is_writeback(cur_op_s);
                end else begin
                    result_next_s = result_r;
                end
            end
            ST_WAIT: begin
                if (result_valid) begin
                    result_next_s = result_data;
                    retire_s      = !is_writeback(cur_op_s);
                end else begin
                    timeout_next_s = wait_terminal_s;
                end
            end
            ST_WRITE: retire_s = 1'b1;
            default:  retire_s = 1'b0;
        endcase
    end

    // FSM output logic, evaluated on the next state so outputs can be registered
    always_comb begin
        instr_ready_next_s     = 1'b0;
        busy_next_s            = 1'b1;
        rf_enable_read_next_s  = 1'b0;
        rf_enable_write_next_s = 1'b0;
        rf_addr1_next_s        = 5'd0;
        rf_addr2_next_s        = 5'd0;
        rf_instr_next_s        = 32'd0;
        rf_data_next_s         = 32'd0;
        exec_valid_next_s      = 1'b0;
        exec_op_next_s         = 5'd0;
        case (state_next_s)
            ST_IDLE: begin
                instr_ready_next_s = 1'b1;
                busy_next_s        = 1'b0;
            end
            ST_READ: begin
                rf_enable_read_next_s = 1'b1;
                rf_addr1_next_s       = instr_next_s[SRC1_MSB:SRC1_LSB];
                rf_addr2_next_s       = instr_next_s[SRC2_MSB:SRC2_LSB];
            end
            ST_EXEC: begin
                exec_valid_next_s = 1'b1;
                exec_op_next_s    = instr_next_s[OPC_MSB:OPC_LSB];
            end
            ST_WAIT: busy_next_s = 1'b1;
            ST_WRITE: begin
                rf_enable_write_next_s = 1'b1;
                rf_instr_next_s        = instr_next_s;
                rf_data_next_s         = result_next_s;
            end
            default: begin
                instr_ready_next_s = 1'b1;
                busy_next_s        = 1'b0;
            end
        endcase
    end

    // Datapath registers: latched instruction, result, operands, retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_r         <= 32'd0;
            result_r        <= 32'd0;
            exec_a_r        <= 32'd0;
            exec_b_r        <= 32'd0;
            retired_count_r <= {CNT_W{1'b0}};
        end else begin
            instr_r  <= instr_next_s;
            result_r <= result_next_s;
            if (state_r == ST_READ) begin
                exec_a_r <= rf_data_out1;
                exec_b_r <= rf_data_out2;
            end else begin
                exec_a_r <= exec_a_r;
                exec_b_r <= exec_b_r;
            end
            if (retire_s) begin
                retired_count_r <= retired_count_r + CNT_W'(1);
            end else begin
                retired_count_r <= retired_count_r;
            end
        end
    end

    // Registered interface outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_ready_r     <= 1'b1;
            busy_r            <= 1'b0;
            rf_enable_read_r  <= 1'b0;
            rf_enable_write_r <= 1'b0;
            rf_addr1_r        <= 5'd0;
            rf_addr2_r        <= 5'd0;
            rf_instr_r        <= 32'd0;
            rf_data_r         <= 32'd0;
            exec_valid_r      <= 1'b0;
            exec_op_r         <= 5'd0;
            timeout_r         <= 1'b0;
            illegal_op_r      <= 1'b0;
        end else begin
            instr_ready_r     <= instr_ready_next_s;
            busy_r            <= busy_next_s;
            rf_enable_read_r  <= rf_enable_read_next_s;
            rf_enable_write_r <= rf_enable_write_next_s;
            rf_addr1_r        <= rf_addr1_next_s;
            rf_addr2_r        <= rf_addr2_next_s;
            rf_instr_r        <= rf_instr_next_s;
            rf_data_r         <= rf_data_next_s;
            exec_valid_r      <= exec_valid_next_s;
            exec_op_r         <= exec_op_next_s;
            timeout_r         <= timeout_next_s;
            illegal_op_r      <= illegal_next_s;
        end
    end

    assign instr_ready     = instr_ready_r;
    assign busy            = busy_r;
    assign rf_enable_read  = rf_enable_read_r;
    assign rf_enable_write = rf_enable_write_r;
    assign rf_addr1        = rf_addr1_r;
    assign rf_addr2        = rf_addr2_r;
    assign rf_instr        = rf_instr_r;
    assign rf_data         = rf_data_r;
    assign exec_valid      = exec_valid_r;
    assign exec_op         = exec_op_r;
    assign exec_a          = exec_a_r;
    assign exec_b          = exec_b_r;
    assign timeout         = timeout_r;
    assign illegal_op      = illegal_op_r;
    assign retired_count   = retired_count_r;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Testbench for regfile_sequencer: register-file model, randomized instruction driver
// with an instruction-level reference model, and a scoreboard monitor.
module tb_regfile_sequencer;
    import regfile_sequencer_pkg::*;

    localparam int T  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   instr_in = 32'd0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [31:0]   rf_instr;
    logic [4:0]    rf_addr1, rf_addr2;
    logic          rf_enable_read, rf_enable_write;
    logic [31:0]   rf_data, rf_data_out1, rf_data_out2;
    logic          exec_valid;
    logic          exec_ready = 1'b0;
    logic [4:0]    exec_op;
    logic [31:0]   exec_a, exec_b;
    logic          result_valid = 1'b0;
    logic [31:0]   result_data = 32'd0;
    logic          busy, timeout, illegal_op;
    logic [CW-1:0] retired_count;

    always #5 clk = ~clk;

    regfile_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .rf_instr(rf_instr), .rf_addr1(rf_addr1),
        .rf_addr2(rf_addr2), .rf_enable_read(rf_enable_read),
        .rf_enable_write(rf_enable_write), .rf_data(rf_data),
        .rf_data_out1(rf_data_out1), .rf_data_out2(rf_data_out2),
        .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_op(exec_op),
        .exec_a(exec_a), .exec_b(exec_b), .result_valid(result_valid),
        .result_data(result_data), .busy(busy), .timeout(timeout),
        .illegal_op(illegal_op), .retired_count(retired_count)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 1) return 32'd5;
        if (i == 2) return 32'd7;
        return 32'(i) * 32'h0101_0101 + 32'd3;
    endfunction

    // Register file: combinational read, MOV copies src2 into dest on write
    logic [31:0] rf_mem [32];
    bit          rf_loaded = 1'b0;
    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
            rf_loaded <= 1'b1;
        end else if (rf_enable_write) begin
            if (rf_instr[31:27] == OP_MOV) rf_mem[rf_instr[26:22]] <= rf_mem[rf_instr[4:0]];
            else                           rf_mem[rf_instr[26:22]] <= rf_data;
        end
    end
    assign rf_data_out1 = rf_mem[rf_addr1];
    assign rf_data_out2 = rf_mem[rf_addr2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_READ, EV_EXEC, EV_WRITE, EV_TIMEOUT, EV_ILLEGAL, EV_DONE} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          cy;
    } ev_t;

    ev_t exp_q[$];
    bit  done_flag = 1'b0;
    int  checks = 0;
    int  errors = 0;

    // ---------------- reference model + driver ----------------
    logic [31:0] ref_regs [32];
    int          exp_count = 0;

    function automatic logic [31:0] model_result(input logic [4:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        case (op)
            OP_LW:   return (a + b) ^ 32'h5A5A_A5A5;
            OP_SW:   return b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_DIV:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_SHL:  return a << b[4:0];
            OP_SHR:  return a >> b[4:0];
            OP_CMP:  return (a < b) ? 32'd1 : 32'd0;
            OP_NOT:  return ~a;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void push_ev(input ev_kind_e k, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] c, input int cy);
        exp_q.push_back('{kind: k, a: a, b: b, c: c, cy: cy});
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 8 && !instr_ready; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // rmode: -1 result with exec_ready, -2 never (timeout), k>=0 result in WAIT cycle k
    task automatic run(input logic [4:0] op, input logic [4:0] dest, input logic [4:0] s1,
                       input logic [4:0] s2, input int rdly, input int rmode, input bit noise);
        logic [31:0] instr, a, b, res;
        int          acc;
        instr = {op, dest, s1, 12'($urandom), s2};
        instr_in    = instr;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr_in    = $urandom;
        acc = cyc;
        if (!is_legal(op)) begin
            push_ev(EV_ILLEGAL, 32'(exp_count), 32'd0, 32'd0, -1);
            return;
        end
        if (op == OP_MOV) begin
            push_ev(EV_WRITE, instr, 32'd0, 32'd0, acc);
            ref_regs[dest] = ref_regs[s2];
            exp_count = (exp_count + 1) % (1 << CW);
            push_ev(EV_DONE, 32'(exp_count), 32'd0, 32'd0, -1);
            wait_idle();
            return;
        end
        a   = ref_regs[s1];
        b   = ref_regs[s2];
        res = model_result(op, a, b);
        push_ev(EV_READ, 32'(s1), 32'(s2), 32'd0, -1);
        push_ev(EV_EXEC, a, b, 32'(op), -1);
        if (rmode == -2) begin
            push_ev(EV_TIMEOUT, 32'd0, 32'd0, 32'd0, -1);
        end else begin
            if (is_writeback(op)) begin
                push_ev(EV_WRITE, instr, res, 32'd0, acc + 2 + rdly + ((rmode >= 0) ? rmode + 1 : 0));
                ref_regs[dest] = res;
            end
            exp_count = (exp_count + 1) % (1 << CW);
        end
        push_ev(EV_DONE, 32'(exp_count), 32'd0, 32'd0, -1);
        // READ cycle: handshakes here must be ignored
        if (noise) begin
            exec_ready   = 1'b1;
            result_valid = 1'b1;
            result_data  = $urandom;
        end
        @(posedge clk); #1;
        exec_ready   = 1'b0;
        result_valid = 1'b0;
        repeat (rdly) begin
            @(posedge clk); #1;
        end
        exec_ready = 1'b1;
        if (rmode == -1) begin
            result_valid = 1'b1;
            result_data  = res;
        end
        @(posedge clk); #1;
        exec_ready   = 1'b0;
        result_valid = 1'b0;
        result_data  = $urandom;
        if (rmode >= 0) begin
            repeat (rmode) begin
                @(posedge clk); #1;
            end
            result_valid = 1'b1;
            result_data  = res;
            @(posedge clk); #1;
            result_valid = 1'b0;
            result_data  = $urandom;
        end else if (rmode == -2) begin
            repeat (T) begin
                @(posedge clk); #1;
            end
        end
        wait_idle();
    endtask

    initial begin
        int sel, rmode;
        for (int i = 0; i < 32; i++) ref_regs[i] = init_val(i);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        run(OP_ADD, 5'd3, 5'd1, 5'd2, 0, -1, 1'b0);    // 5 + 7 = 12, fastest path
        run(OP_MOV, 5'd4, 5'd0, 5'd3, 0, -1, 1'b0);    // r4 <= r3
        run(OP_SW,  5'd5, 5'd6, 5'd7, 3,  2, 1'b1);    // stalled handshake, late result
        run(OP_ADD, 5'd8, 5'd9, 5'd10, 0, -2, 1'b0);   // result never comes
        run(5'd20,  5'd1, 5'd2, 5'd3, 0, -1, 1'b0);    // undefined opcode
        run(OP_CMP, 5'd1, 5'd3, 5'd4, 1,  3, 1'b0);    // result on terminal wait cycle

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 7);
            if (sel == 0)      rmode = -2;
            else if (sel <= 3) rmode = -1;
            else               rmode = $urandom_range(0, T - 1);
            run(5'($urandom_range(0, 16)), 5'($urandom), 5'($urandom), 5'($urandom),
                $urandom_range(0, 2), rmode, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while waiting for a result
        instr_in    = {OP_ADD, 5'd6, 5'd1, 12'd0, 5'd2};
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        push_ev(EV_READ, 32'd1, 32'd2, 32'd0, -1);
        push_ev(EV_EXEC, ref_regs[1], ref_regs[2], 32'(OP_ADD), -1);
        @(posedge clk); #1;
        exec_ready = 1'b1;
        @(posedge clk); #1;
        exec_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_count = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Counter wrap: sixteen retirements bring the 4-bit count back to 0
        for (int n = 0; n < 16; n++) begin
            run(OP_MOV, 5'($urandom), 5'd0, 5'($urandom), 0, -1, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1 done_flag = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach its end, got time %0t, required < 200000", $time);
        $fatal(1);
    end

    // ---------------- scoreboard monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic take(input ev_kind_e k, output ev_t ev, output bit ok);
        checks++;
        ok = 1'b0;
        ev = '{kind: k, a: 32'd0, b: 32'd0, c: 32'd0, cy: -1};
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_%s: DUT produced it, required nothing (cycle %0d)", k.name(), cyc);
        end else begin
            ev = exp_q.pop_front();
            if (ev.kind != k) begin
                errors++;
                $display("FAIL event_order: actual %s, required %s (cycle %0d)", k.name(), ev.kind.name(), cyc);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    initial begin
        ev_t ev, cur_exec;
        bit  ok, prev_ready, prev_exec;
        int  busy_cnt;
        prev_ready = 1'b1;
        prev_exec  = 1'b0;
        busy_cnt   = 0;
        cur_exec   = '{kind: EV_EXEC, a: 32'd0, b: 32'd0, c: 32'd0, cy: -1};
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_ready", 32'(instr_ready), 32'd1);
                chk("reset_ctrl", 32'({busy, timeout, illegal_op, rf_enable_read, rf_enable_write, exec_valid}), 32'd0);
                chk("reset_addr_op", 32'({rf_addr1, rf_addr2, exec_op}), 32'd0);
                chk("reset_rf_instr", rf_instr, 32'd0);
                chk("reset_rf_data", rf_data, 32'd0);
                chk("reset_exec_a", exec_a, 32'd0);
                chk("reset_exec_b", exec_b, 32'd0);
                chk("reset_count", 32'(retired_count), 32'd0);
                exp_q.delete();
                prev_ready = instr_ready;
                prev_exec  = 1'b0;
                busy_cnt   = 0;
            end else begin
                chk("enable_exclusive", 32'(rf_enable_read && rf_enable_write), 32'd0);
                if (!rf_enable_read)  chk("addr_idle", 32'({rf_addr1, rf_addr2}), 32'd0);
                if (!rf_enable_write) chk("rf_instr_idle", rf_instr, 32'd0);
                if (rf_enable_read) begin
                    take(EV_READ, ev, ok);
                    if (ok) begin
                        chk("read_addr1", 32'(rf_addr1), ev.a);
                        chk("read_addr2", 32'(rf_addr2), ev.b);
                    end
                end
                if (exec_valid) begin
                    if (!prev_exec) begin
                        take(EV_EXEC, ev, ok);
                        if (ok) cur_exec = ev;
                    end
                    chk("exec_op", 32'(exec_op), cur_exec.c);
                    chk("exec_a", exec_a, cur_exec.a);
                    chk("exec_b", exec_b, cur_exec.b);
                end
                if (rf_enable_write) begin
                    take(EV_WRITE, ev, ok);
                    if (ok) begin
                        chk("write_instr", rf_instr, ev.a);
                        chk("write_data", rf_data, ev.b);
                        chk("write_cycle", 32'(cyc), 32'(ev.cy));
                    end
                end
                if (timeout) take(EV_TIMEOUT, ev, ok);
                if (illegal_op) begin
                    take(EV_ILLEGAL, ev, ok);
                    if (ok) chk("illegal_count", 32'(retired_count), ev.a);
                end
                if (instr_ready && !prev_ready) begin
                    take(EV_DONE, ev, ok);
                    if (ok) chk("retired_count", 32'(retired_count), ev.a);
                end
                busy_cnt = busy ? busy_cnt + 1 : 0;
                if (busy_cnt == 40) begin
                    checks++;
                    errors++;
                    $display("FAIL busy_bound: busy for %0d cycles, required < 40", busy_cnt);
                end
                prev_ready = instr_ready;
                prev_exec  = exec_valid;
                if (done_flag) begin
                    chk("queue_drained", 32'(exp_q.size()), 32'd0);
                    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                    $finish;
                end
            end
        end
    end

endmodule
